os_chan_arbiter: RTL
====================

Name: os_chan_arbiter

Overview:
- Round-robin scheduler that shares the single-issue oversample filter input (dv/chan/data, one sample per cycle, no backpressure) between N_CHAN independent sample sources.
- Each source has a one-deep holding register and a valid/ready handshake.
- Per-channel enables are configured over the standard wr_en/wr_addr/wr_chan/wr_data endpoint bus.
- Sits between the ADC front-end deserializers and the oversample filter.

Parameters:
- N_CHAN, 4, number of requesting sources (2..32)
- W_CHAN, 5, channel index width; requires 2**W_CHAN >= N_CHAN
- W_DATA, 18, signed sample width
- W_WR_ADDR, 16, config address width
- W_WR_CHAN, 5, config channel width
- W_WR_DATA, 49, config data width; requires >= N_CHAN
- ARB_EN_ADDR, 16'h0040, address of the channel-enable mask register
- ARB_OVR_CLR_ADDR, 16'h0041, address that clears overrun flags
- EN_INIT, all ones, reset value of the enable mask

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- src_valid  in  N_CHAN  per-source sample valid
- src_data  in  N_CHAN*W_DATA  packed signed samples; source i occupies bits [i*W_DATA +: W_DATA]
- src_ready  out  N_CHAN  per-source accept
- wr_en  in  1  config write strobe
- wr_addr  in  W_WR_ADDR  config address
- wr_chan  in  W_WR_CHAN  config channel (ignored by this block)
- wr_data  in  W_WR_DATA  config data
- dv_out  out  1  sample valid to the filter
- chan_out  out  W_CHAN  channel index of the issued sample
- data_out  out  W_DATA  issued sample
- overrun_out  out  N_CHAN  sticky overrun flags (see Optional Feature)

Behaviour:
- Reset (rst_in high at a clock edge):
  - pend = 0, en_mask = EN_INIT, rr_ptr = 0.
  - dv_out = 0, chan_out = 0, data_out = 0, overrun_out = 0.
  - src_ready is low while rst_in is high.
- src_ready[i] = !rst_in && (!pend[i] || grant[i] || !en_mask[i]). This is combinational.
- Accept:
  - Occurs when src_valid[i] && src_ready[i] && en_mask[i].
  - At the edge, hold[i] <= sample and pend[i] <= 1.
  - If the channel is disabled, the sample is consumed and discarded, and pend[i] stays 0.
- Grant:
  - Combinational over req = pend & en_mask.
  - Picks the first set bit at or after rr_ptr, wrapping N_CHAN-1 to 0.
  - At most one grant per cycle.
- Issue:
  - On grant of channel g: dv_out <= 1, chan_out <= g, data_out <= hold[g], pend[g] cleared, rr_ptr <= (g+1) mod N_CHAN.
  - With no grant: dv_out <= 0, and chan_out/data_out hold their last value.
- Simultaneous grant and accept on the same channel: the new sample loads and pend stays 1. No bubble, so a single source can sustain 1 sample/cycle.
- Latency: accept at edge T, earliest dv_out at edge T+1 (dv_out visible in the cycle after the sample's pend is set, i.e. 2 cycles from src_valid to dv_out).
- Fairness: with all N_CHAN channels continuously pending, each channel issues exactly once per N_CHAN cycles.
- Config:
  - A write with wr_en && wr_addr == ARB_EN_ADDR sets en_mask <= wr_data[N_CHAN-1:0] at the edge; the new mask is effective next cycle.
  - Channels disabled by the write have pend cleared on the same edge, and their held sample is dropped without issue.
  - Writes during rst_in are ignored.
- A grant on the same edge as a disabling write still issues. The write affects grant only from the next cycle.
- Reset mid-operation clears all pending samples with no partial issue.
- A sample already issued at the edge coincident with reset does not assert dv_out.

Optional Feature:
- Macro: OS_ARB_OVERRUN_EN.
- Defined:
  - overrun_out[i] sets when src_valid[i] && !src_ready[i] (source stalled while its holding register is full and not granted).
  - Flags are sticky until a write with wr_addr == ARB_OVR_CLR_ADDR clears the bits where wr_data[i]=1. Set wins over a same-cycle clear.
  - Flags are cleared by reset.
- Undefined: overrun_out is tied to 0 and there is no flag logic.

Test Plan:
- Reset, then src_valid[2]=1 with data 18'h1F00A for one cycle -> src_ready[2]=1, then two cycles later dv_out=1, chan_out=2, data_out=18'h1F00A for exactly one cycle.
- All 4 sources valid continuously with distinct constant data -> dv_out stays high and chan_out sequence is 0,1,2,3,0,1,... with no repeats or skips over 16 cycles.
- Source 1 alone valid every cycle with an incrementing count -> dv_out high every cycle after the latency, data_out increments by 1 each cycle, no drops.
- Write ARB_EN_ADDR with wr_data=4'b1011 while channel 2 is pending -> channel 2 is never issued, src_ready[2]=1, and channels 0, 1, 3 continue round-robin.
- Hold channel 0 pending while channels 1-3 saturate, and keep src_valid[0] high -> src_ready[0]=0 for at most 3 cycles between issues. With OS_ARB_OVERRUN_EN, overrun_out[0]=1 and it clears after a write to ARB_OVR_CLR_ADDR with wr_data=1.
- Assert rst_in for 1 cycle while channels 0-3 are all pending -> dv_out=0 the next cycle, no stale samples issue afterwards, and en_mask returns to 4'b1111.

Source files
------------

// File: rtl/os_chan_arbiter.sv
// os_chan_arbiter: round-robin scheduler that merges N_CHAN sample sources,
// each with a one-deep holding register, onto the single-issue oversample
// filter input (dv/chan/data, one sample per cycle, no backpressure).
// Source handshake: a sample transfers on a clock edge where src_valid[i] and
// src_ready[i] are both high; src_ready is combinational from state and reset.
// Optional build macro: OS_ARB_OVERRUN_EN adds sticky per-source overrun flags.
module os_chan_arbiter #(
    parameter int                    N_CHAN           = 4,
    parameter int                    W_CHAN           = 5,
    parameter int                    W_DATA           = 18,
    parameter int                    W_WR_ADDR        = 16,
    parameter int                    W_WR_CHAN        = 5,
    parameter int                    W_WR_DATA        = 49,
    parameter logic [W_WR_ADDR-1:0]  ARB_EN_ADDR      = 16'h0040,
    parameter logic [W_WR_ADDR-1:0]  ARB_OVR_CLR_ADDR = 16'h0041,
    parameter logic [N_CHAN-1:0]     EN_INIT          = '1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [N_CHAN-1:0]          src_valid,
    input  logic [N_CHAN*W_DATA-1:0]   src_data,
    output logic [N_CHAN-1:0]          src_ready,
    input  logic                       wr_en,
    input  logic [W_WR_ADDR-1:0]       wr_addr,
    input  logic [W_WR_CHAN-1:0]       wr_chan,
    input  logic [W_WR_DATA-1:0]       wr_data,
    output logic                       dv_out,
    output logic [W_CHAN-1:0]          chan_out,
    output logic [W_DATA-1:0]          data_out,
    output logic [N_CHAN-1:0]          overrun_out
);

    logic [N_CHAN-1:0]   pend_q, pend_d;
    logic [N_CHAN-1:0]   en_mask_q, en_mask_d;
    logic [W_CHAN-1:0]   rr_ptr_q, rr_ptr_d;
    logic [W_DATA-1:0]   hold_q [N_CHAN];
    logic [W_DATA-1:0]   hold_d [N_CHAN];
    logic                dv_q, dv_d;
    logic [W_CHAN-1:0]   chan_q, chan_d;
    logic [W_DATA-1:0]   data_q, data_d;

    logic [N_CHAN-1:0]   req;
    logic [2*N_CHAN-1:0] req_dbl;
    logic [N_CHAN-1:0]   req_rot;
    logic [W_CHAN-1:0]   grant_ofs;
    logic [W_CHAN:0]     grant_sum;
    logic [W_CHAN-1:0]   grant_idx;
    logic                grant_vld;
    logic [N_CHAN-1:0]   grant;
    logic [W_DATA-1:0]   issue_data;
    logic [N_CHAN-1:0]   ready;
    logic [N_CHAN-1:0]   accept;
    logic                en_wr;
    logic                cfg_unused;

    // wr_chan is part of the shared endpoint bus but carries nothing for us.
    assign cfg_unused = ^{wr_chan, wr_data};

    assign req       = pend_q & en_mask_q;
    assign en_wr     = wr_en && (wr_addr == ARB_EN_ADDR);
    assign ready     = {N_CHAN{!rst_in}} & (~pend_q | grant | ~en_mask_q);
    assign accept    = src_valid & ready & en_mask_q;
    assign src_ready = ready;

    // Round-robin pick: rotate requests so rr_ptr lands at bit 0, take the
    // lowest set bit, then map the offset back to an absolute channel.
    always_comb begin
        req_dbl   = {req, req} >> rr_ptr_q;
        req_rot   = req_dbl[N_CHAN-1:0];
        grant_vld = 1'b0;
        grant_ofs = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (!grant_vld && req_rot[k]) begin
                grant_vld = 1'b1;
                grant_ofs = W_CHAN'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_ofs};
        if (grant_sum >= (W_CHAN+1)'(N_CHAN)) begin
            grant_sum = grant_sum - (W_CHAN+1)'(N_CHAN);
        end
        grant_idx = grant_sum[W_CHAN-1:0];
        grant     = '0;
        if (grant_vld) begin
            grant = {{(N_CHAN-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

    // Select the held sample of the granted channel (one-hot mux).
    always_comb begin
        issue_data = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (grant[k]) begin
                issue_data = hold_q[k];
            end
        end
    end

    // Next state: issue, accept (a same-cycle grant+accept keeps pend set),
    // and mask writes that drop samples of newly disabled channels.
    always_comb begin
        dv_d      = grant_vld;
        chan_d    = chan_q;
        data_d    = data_q;
        rr_ptr_d  = rr_ptr_q;
        en_mask_d = en_mask_q;
        if (grant_vld) begin
            chan_d   = grant_idx;
            data_d   = issue_data;
            rr_ptr_d = (grant_idx == W_CHAN'(N_CHAN-1)) ? '0 : grant_idx + 1'b1;
        end
        pend_d = (pend_q & ~grant) | accept;
        if (en_wr) begin
            en_mask_d = wr_data[N_CHAN-1:0];
            pend_d    = pend_d & wr_data[N_CHAN-1:0];
        end
    end

    // Holding registers load on accept.
    always_comb begin
        for (int k = 0; k < N_CHAN; k++) begin
            hold_d[k] = accept[k] ? src_data[k*W_DATA +: W_DATA] : hold_q[k];
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_q    <= '0;
            en_mask_q <= EN_INIT;
            rr_ptr_q  <= '0;
            dv_q      <= 1'b0;
            chan_q    <= '0;
            data_q    <= '0;
        end else begin
            pend_q    <= pend_d;
            en_mask_q <= en_mask_d;
            rr_ptr_q  <= rr_ptr_d;
            dv_q      <= dv_d;
            chan_q    <= chan_d;
            data_q    <= data_d;
        end
    end

    // Sample storage needs no reset: it is only read while pend is set.
    always_ff @(posedge clk_in) begin
        hold_q <= hold_d;
    end

    assign dv_out   = dv_q;
    assign chan_out = chan_q;
    assign data_out = data_q;

`ifdef OS_ARB_OVERRUN_EN
    logic [N_CHAN-1:0] ovr_q, ovr_d;
    logic              ovr_clr;

    assign ovr_clr = wr_en && (wr_addr == ARB_OVR_CLR_ADDR);

    // Sticky stall flags; a new stall wins over a same-cycle clear.
    always_comb begin
        ovr_d = ovr_q;
        if (ovr_clr) begin
            ovr_d = ovr_d & ~wr_data[N_CHAN-1:0];
        end
        ovr_d = ovr_d | (src_valid & ~ready);
    end

    // Overrun flag register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_out = ovr_q;
`else
    assign overrun_out = '0;
`endif

endmodule
